// File: rtl/bcd_modcnt_pkg.sv
// Shared BCD constants and elaboration-time helpers for the BCD modulo counter.
package bcd_modcnt_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  BCD_NINE   = 4'd9;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned BCD_MAX_W  = BCD_W * MAX_DIGITS;

  // Decimal integer to packed BCD, digit 0 in the low nibble.
  function automatic logic [BCD_MAX_W-1:0] to_bcd(input int unsigned val);
    logic [BCD_MAX_W-1:0] r;
    int unsigned          v;
    r = '0;
    v = val;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      r[i*BCD_W +: BCD_W] = 4'(v % 32'd10);
      v = v / 32'd10;
    end
    return r;
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_modcnt_if.sv
// Control/load/result bundle between a BCD counter and whoever drives it.
interface bcd_modcnt_if #(
  parameter int unsigned DIGITS = 2
);
  import bcd_modcnt_pkg::*;

  localparam int unsigned W = BCD_W * DIGITS;

  logic         en;
  logic         inc;
  logic         dec;
  logic         load;
  logic [W-1:0] ldval;
  logic [W-1:0] q;
  logic         co;
  logic         bo;
  logic         lderr;

  modport master (
    output en, inc, dec, load, ldval,
    input  q, co, bo, lderr
  );

  modport slave (
    input  en, inc, dec, load, ldval,
    output q, co, bo, lderr
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit cell: steps up or down when enabled and reports ripple carry/borrow.
module bcd_digit
  import bcd_modcnt_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             up,
  input  logic             down,
  input  logic             cin,
  input  logic             bin,
  output logic [BCD_W-1:0] nxt_c,
  output logic             cout_c,
  output logic             bout_c
);

  always_comb begin
    nxt_c  = d;
    cout_c = 1'b0;
    bout_c = 1'b0;
    if (up && cin) begin
      if (d >= BCD_NINE) begin
        nxt_c  = '0;
        cout_c = 1'b1;
      end else begin
        nxt_c = 4'(d + 4'd1);
      end
    end else if (down && bin) begin
      if (d == 4'd0) begin
        nxt_c  = BCD_NINE;
        bout_c = 1'b1;
      end else begin
        nxt_c = 4'(d - 4'd1);
      end
    end
  end

endmodule

// File: rtl/bcd_modcnt.sv
// Packed-BCD modulo counter over MINVAL..MAXVAL with up/down step, checked
// parallel load and registered carry/borrow/load-error pulses for cascading.
module bcd_modcnt
  import bcd_modcnt_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned MINVAL = 0,
  parameter int unsigned MAXVAL = 23
) (
  input  logic          clk,
  input  logic          rst,
  bcd_modcnt_if.slave   bus
);

  localparam int unsigned W = BCD_W * DIGITS;

  if (DIGITS == 0 || DIGITS > MAX_DIGITS || MINVAL >= MAXVAL ||
      MAXVAL >= pow10(DIGITS)) begin : g_bad_params
    $error("bcd_modcnt: need 0 < DIGITS <= 8 and MINVAL < MAXVAL < 10**DIGITS");
  end

  localparam logic [W-1:0] MIN_BCD = W'(to_bcd(MINVAL));
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAXVAL));

  logic [W-1:0]  q_r, q_nxt;
  logic          co_r, co_nxt;
  logic          bo_r, bo_nxt;
  logic          lderr_r, lderr_nxt;

  logic          step_up, step_dn;
  logic [W-1:0]  step_val;
  logic [DIGITS:0] cy, bw;

  // Simultaneous up and down requests cancel; EN and INC merge into one step.
  assign step_up = (bus.en | bus.inc) & ~bus.dec;
  assign step_dn = bus.dec & ~(bus.en | bus.inc);

  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_digit u_digit (
      .d      (q_r[i*BCD_W +: BCD_W]),
      .up     (step_up),
      .down   (step_dn),
      .cin    (cy[i]),
      .bin    (bw[i]),
      .nxt_c  (step_val[i*BCD_W +: BCD_W]),
      .cout_c (cy[i+1]),
      .bout_c (bw[i+1])
    );
  end

  // Range wrap on the packed value; a ripple out of the top digit also wraps.
  logic wrap_up, wrap_dn;
  assign wrap_up = (q_r == MAX_BCD) | cy[DIGITS];
  assign wrap_dn = (q_r == MIN_BCD) | bw[DIGITS];

  // Load validation: every nibble a decimal digit and value inside the range.
  logic ld_digits_ok, ld_ge_min, ld_le_max, ld_ok;

  always_comb begin
    ld_digits_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.ldval[i*BCD_W +: BCD_W] > BCD_NINE) ld_digits_ok = 1'b0;
    end
  end

  if (MINVAL == 0) begin : g_min_zero
    assign ld_ge_min = 1'b1;
  end else begin : g_min_cmp
    assign ld_ge_min = (bus.ldval >= MIN_BCD);
  end

  assign ld_le_max = (bus.ldval <= MAX_BCD);
  assign ld_ok     = ld_digits_ok & ld_ge_min & ld_le_max;

  // Next state: LOAD beats stepping; pulses default low every cycle.
  always_comb begin
    q_nxt     = q_r;
    co_nxt    = 1'b0;
    bo_nxt    = 1'b0;
    lderr_nxt = 1'b0;
    if (bus.load) begin
      if (ld_ok) begin
        q_nxt = bus.ldval;
      end else begin
        lderr_nxt = 1'b1;
      end
    end else if (step_up) begin
      if (wrap_up) begin
        q_nxt  = MIN_BCD;
        co_nxt = 1'b1;
      end else begin
        q_nxt = step_val;
      end
    end else if (step_dn) begin
      if (wrap_dn) begin
        q_nxt  = MAX_BCD;
        bo_nxt = 1'b1;
      end else begin
        q_nxt = step_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= MIN_BCD;
      co_r    <= 1'b0;
      bo_r    <= 1'b0;
      lderr_r <= 1'b0;
    end else begin
      q_r     <= q_nxt;
      co_r    <= co_nxt;
      bo_r    <= bo_nxt;
      lderr_r <= lderr_nxt;
    end
  end

  assign bus.q     = q_r;
  assign bus.co    = co_r;
  assign bus.bo    = bo_r;
  assign bus.lderr = lderr_r;

endmodule

// File: tb/tb_bcd_modcnt.sv
// Scoreboard bench for bcd_modcnt: a 0..23 and a 1..12 instance share stimulus
// and are checked against a decimal-integer reference model.
module tb_bcd_modcnt;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_modcnt_if #(.DIGITS(2)) b24 ();
  bcd_modcnt_if #(.DIGITS(2)) b12 ();

  bcd_modcnt #(.DIGITS(2), .MINVAL(0), .MAXVAL(23)) u24 (
    .clk (clk),
    .rst (rst),
    .bus (b24)
  );

  bcd_modcnt #(.DIGITS(2), .MINVAL(1), .MAXVAL(12)) u12 (
    .clk (clk),
    .rst (rst),
    .bus (b12)
  );

  typedef struct {
    int q;
    bit co;
    bit bo;
    bit lderr;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t sb[$];
  pair_t mon_p;
  int    errors = 0;
  int    checks = 0;
  int    m24 = 0;
  int    m12 = 1;

  function automatic int to_bcd8(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  // Reference: counter value held as a plain decimal integer.
  function automatic exp_t model(input int lo, input int hi, input bit r,
                                 input bit en, input bit inc, input bit dec,
                                 input bit ld, input logic [7:0] lv, inout int m);
    exp_t e;
    int   dh, dl, v;
    bit   up;
    dh = int'(lv[7:4]);
    dl = int'(lv[3:0]);
    up = en | inc;
    e.co = 0; e.bo = 0; e.lderr = 0;
    if (r) begin
      m = lo;
    end else if (ld) begin
      v = dh * 10 + dl;
      if (dh <= 9 && dl <= 9 && v >= lo && v <= hi) m = v;
      else e.lderr = 1;
    end else if (up && !dec) begin
      if (m == hi) begin m = lo; e.co = 1; end
      else m = m + 1;
    end else if (dec && !up) begin
      if (m == lo) begin m = hi; e.bo = 1; end
      else m = m - 1;
    end
    e.q = to_bcd8(m);
    return e;
  endfunction

  task automatic drive(input bit r, input bit en, input bit inc, input bit dec,
                       input bit ld, input logic [7:0] lv);
    pair_t p;
    @(negedge clk);
    rst = r;
    b24.en = en; b24.inc = inc; b24.dec = dec; b24.load = ld; b24.ldval = lv;
    b12.en = en; b12.inc = inc; b12.dec = dec; b12.load = ld; b12.ldval = lv;
    p.a = model(0, 23, r, en, inc, dec, ld, lv, m24);
    p.b = model(1, 12, r, en, inc, dec, ld, lv, m12);
    sb.push_back(p);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_p = sb.pop_front();
      chk("q24",     int'(b24.q),     mon_p.a.q);
      chk("co24",    int'(b24.co),    int'(mon_p.a.co));
      chk("bo24",    int'(b24.bo),    int'(mon_p.a.bo));
      chk("lderr24", int'(b24.lderr), int'(mon_p.a.lderr));
      chk("q12",     int'(b12.q),     mon_p.b.q);
      chk("co12",    int'(b12.co),    int'(mon_p.b.co));
      chk("bo12",    int'(b12.bo),    int'(mon_p.b.bo));
      chk("lderr12", int'(b12.lderr), int'(mon_p.b.lderr));
    end
  end

  initial begin
    logic [7:0] lv;
    bit r, en, inc, dec, ld;
    rst = 1'b1;
    b24.en = 0; b24.inc = 0; b24.dec = 0; b24.load = 0; b24.ldval = '0;
    b12.en = 0; b12.inc = 0; b12.dec = 0; b12.load = 0; b12.ldval = '0;

    // Reset held with EN active
    drive(1, 1, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 0, 8'h00);
    // Full upward cycle through the hour range
    repeat (24) drive(0, 1, 0, 0, 0, 8'h00);
    // Borrow from minimum, then plain decrement
    drive(0, 0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 1, 0, 8'h00);
    // Loads: accepted, out of range, non-BCD, load beats step
    drive(0, 0, 0, 0, 1, 8'h19);
    drive(0, 0, 0, 0, 1, 8'h24);
    drive(0, 0, 0, 0, 1, 8'h1A);
    drive(0, 1, 0, 0, 1, 8'h07);
    drive(0, 0, 0, 0, 0, 8'h00);
    // Up and down cancel; EN with INC is one step
    drive(0, 0, 0, 0, 1, 8'h05);
    drive(0, 1, 0, 1, 0, 8'h00);
    drive(0, 1, 1, 0, 0, 8'h00);
    // 1..12 wrap both ways, then reset during a wrap
    drive(0, 0, 0, 0, 1, 8'h12);
    drive(0, 1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 1, 8'h12);
    drive(1, 1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 1) == 1);
      inc = ($urandom_range(0, 9) == 0);
      dec = ($urandom_range(0, 3) == 0);
      ld  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 1) lv = 8'($urandom_range(0, 255));
      else lv = 8'(to_bcd8(int'($urandom_range(0, 29))));
      drive(r, en, inc, dec, ld, lv);
    end
    drive(0, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
